// File: rtl/fork_fetch_pkg.sv
// Shared types and defaults for the fork fetch controller.
package fork_fetch_pkg;
  localparam int PC_W_DEF     = 10;
  localparam int RESET_PC_DEF = 0;
  localparam int CNT_W        = 16;

  typedef enum logic [1:0] {
    SINGLE = 2'd0,
    FORKED = 2'd1,
    HOLD   = 2'd2
  } state_e;
endpackage

// File: rtl/fork_fetch_control_if.sv
// Fetch-control bus: fork/resolve inputs and registered PC/status outputs.
// Counter signals exist only when FORK_FETCH_PERF_EN is defined.
interface fork_fetch_control_if import fork_fetch_pkg::*; #(
  parameter int PC_W = PC_W_DEF
);
  logic            stall;
  logic            fork_req;
  logic [PC_W-1:0] fork_bta;
  logic [PC_W-1:0] fork_ft;
  logic            correct_en_t;
  logic [PC_W-1:0] correction_t;
  logic            correct_en_n;
  logic [PC_W-1:0] correction_n;
  logic [PC_W-1:0] pc_t;
  logic [PC_W-1:0] pc_n;
  logic            forked;
  logic            fork_hold;
  logic            surv_t;
`ifdef FORK_FETCH_PERF_EN
  logic [CNT_W-1:0] fork_cnt;
  logic [CNT_W-1:0] mispred_t_cnt;
  logic [CNT_W-1:0] hold_cyc_cnt;
`endif

  // Upstream side: decode/resolver drive events, observe the PCs.
  modport master (
    output stall, fork_req, fork_bta, fork_ft,
    output correct_en_t, correction_t, correct_en_n, correction_n,
    input  pc_t, pc_n, forked, fork_hold, surv_t
`ifdef FORK_FETCH_PERF_EN
    , input fork_cnt, mispred_t_cnt, hold_cyc_cnt
`endif
  );

  // Controller side.
  modport slave (
    input  stall, fork_req, fork_bta, fork_ft,
    input  correct_en_t, correction_t, correct_en_n, correction_n,
    output pc_t, pc_n, forked, fork_hold, surv_t
`ifdef FORK_FETCH_PERF_EN
    , output fork_cnt, mispred_t_cnt, hold_cyc_cnt
`endif
  );
endinterface

// File: rtl/fork_perf_cnt.sv
// Saturating event counter with enable and async active-high reset.
module fork_perf_cnt import fork_fetch_pkg::*; #(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  // Count enabled events, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt_q <= '0;
    else if (en_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/fork_fetch_control.sv
// Fetch PC controller for the taken/not-taken eager-execution pipes.
// Forks both pipes on an ID branch, rejoins on resolution, and parks a
// second fork in HOLD until the first resolves.
// Optional counters: define FORK_FETCH_PERF_EN.
module fork_fetch_control import fork_fetch_pkg::*; #(
  parameter int PC_W     = PC_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  fork_fetch_control_if.slave  bus
);
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_t_q, pc_t_d, pc_n_q, pc_n_d;
  logic [PC_W-1:0] bta_q, bta_d, ft_q, ft_d;
  logic            surv_q, surv_d;
  logic            corr_t, corr_n;

  // Simultaneous corrections are illegal and treated as no correction.
  assign corr_t = bus.correct_en_t & ~bus.correct_en_n;
  assign corr_n = bus.correct_en_n & ~bus.correct_en_t;

  // State, PCs, pending fork and survivor flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SINGLE;
      pc_t_q  <= RST_PC;
      pc_n_q  <= RST_PC;
      bta_q   <= '0;
      ft_q    <= '0;
      surv_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_t_q  <= pc_t_d;
      pc_n_q  <= pc_n_d;
      bta_q   <= bta_d;
      ft_q    <= ft_d;
      surv_q  <= surv_d;
    end
  end

  // Next-state / next-PC selection; stall freezes everything.
  always_comb begin
    state_d = state_q;
    pc_t_d  = pc_t_q;
    pc_n_d  = pc_n_q;
    bta_d   = bta_q;
    ft_d    = ft_q;
    surv_d  = surv_q;
    if (!bus.stall) begin
      unique case (state_q)
        SINGLE: begin
          if (bus.fork_req) begin
            pc_t_d  = bus.fork_bta;
            pc_n_d  = bus.fork_ft;
            state_d = FORKED;
          end else begin
            pc_t_d = pc_t_q + 1'b1;
            pc_n_d = pc_n_q + 1'b1;
          end
        end
        FORKED: begin
          if (bus.fork_req && (corr_t || corr_n)) begin
            // New fork overrides the rejoin; survivor still recorded.
            pc_t_d = bus.fork_bta;
            pc_n_d = bus.fork_ft;
            surv_d = corr_n;
          end else if (bus.fork_req) begin
            bta_d   = bus.fork_bta;
            ft_d    = bus.fork_ft;
            state_d = HOLD;
          end else if (corr_t) begin
            pc_t_d  = bus.correction_t;
            pc_n_d  = pc_n_q + 1'b1;
            surv_d  = 1'b0;
            state_d = SINGLE;
          end else if (corr_n) begin
            pc_n_d  = bus.correction_n;
            pc_t_d  = pc_t_q + 1'b1;
            surv_d  = 1'b1;
            state_d = SINGLE;
          end else begin
            pc_t_d = pc_t_q + 1'b1;
            pc_n_d = pc_n_q + 1'b1;
          end
        end
        HOLD: begin
          // PCs frozen until the outstanding branch resolves, then the
          // parked fork is applied on that same edge.
          if (corr_t || corr_n) begin
            pc_t_d  = bta_q;
            pc_n_d  = ft_q;
            surv_d  = corr_n;
            state_d = FORKED;
          end
        end
        default: state_d = SINGLE;
      endcase
    end
  end

  assign bus.pc_t      = pc_t_q;
  assign bus.pc_n      = pc_n_q;
  assign bus.forked    = (state_q != SINGLE);
  assign bus.fork_hold = (state_q == HOLD);
  assign bus.surv_t    = surv_q;

`ifdef FORK_FETCH_PERF_EN
  logic fork_inc, mis_t_inc, hold_inc;

  assign fork_inc  = ~bus.stall & (
                       (state_q == SINGLE & bus.fork_req) |
                       (state_q == FORKED & bus.fork_req & (corr_t | corr_n)) |
                       (state_q == HOLD   & (corr_t | corr_n)));
  assign mis_t_inc = ~bus.stall & corr_t & (state_q != SINGLE);
  assign hold_inc  = ~bus.stall & (state_q == HOLD);

  fork_perf_cnt #(.W(CNT_W)) u_fork_cnt (
    .clk(clk), .rst(rst), .en_i(fork_inc),  .cnt_o(bus.fork_cnt));
  fork_perf_cnt #(.W(CNT_W)) u_mis_t_cnt (
    .clk(clk), .rst(rst), .en_i(mis_t_inc), .cnt_o(bus.mispred_t_cnt));
  fork_perf_cnt #(.W(CNT_W)) u_hold_cnt (
    .clk(clk), .rst(rst), .en_i(hold_inc),  .cnt_o(bus.hold_cyc_cnt));
`endif

  // Resolver must never flag both pipes wrong at once.
  a_one_correction: assert property (@(posedge clk) disable iff (rst)
    !(bus.correct_en_t && bus.correct_en_n));
endmodule

// File: tb/tb_fork_fetch_control.sv
// Directed bench for fork_fetch_control; counter checks under FORK_FETCH_PERF_EN.
module tb_fork_fetch_control;
  import fork_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fork_fetch_control_if #(.PC_W(10)) bus ();
  fork_fetch_control_if #(.PC_W(10)) bus2 ();

  fork_fetch_control #(.PC_W(10), .RESET_PC(0))    dut  (.clk(clk), .rst(rst), .bus(bus));
  fork_fetch_control #(.PC_W(10), .RESET_PC(1022)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [31:0] t, input logic [31:0] n,
                        input logic f, input logic h, input logic s);
    chk({tag, ".pc_t"}, 32'(bus.pc_t), t);
    chk({tag, ".pc_n"}, 32'(bus.pc_n), n);
    chk({tag, ".forked"}, 32'(bus.forked), 32'(f));
    chk({tag, ".hold"}, 32'(bus.fork_hold), 32'(h));
    chk({tag, ".surv_t"}, 32'(bus.surv_t), 32'(s));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.fork_req = 0; bus.fork_bta = '0; bus.fork_ft = '0;
    bus.correct_en_t = 0; bus.correction_t = '0;
    bus.correct_en_n = 0; bus.correction_n = '0;
  endtask

  task automatic do_fork(input logic [9:0] b, input logic [9:0] f);
    bus.fork_req = 1; bus.fork_bta = b; bus.fork_ft = f;
  endtask

  initial begin
    idle();
    bus2.stall = 0; bus2.fork_req = 0; bus2.fork_bta = '0; bus2.fork_ft = '0;
    bus2.correct_en_t = 0; bus2.correction_t = '0;
    bus2.correct_en_n = 0; bus2.correction_n = '0;

    // Reset state
    repeat (2) tick();
    chk_st("reset", 0, 0, 0, 0, 1);
    chk("reset.pc2", 32'(bus2.pc_t), 1022);
`ifdef FORK_FETCH_PERF_EN
    chk("reset.fork_cnt", 32'(bus.fork_cnt), 0);
    chk("reset.hold_cnt", 32'(bus.hold_cyc_cnt), 0);
`endif
    rst = 0;

    // Lockstep counting and wrap at 1023
    tick();
    chk_st("single1", 1, 1, 0, 0, 1);
    chk("wrap.1023", 32'(bus2.pc_t), 1023);
    tick();
    chk_st("single2", 2, 2, 0, 0, 1);
    chk("wrap.0.t", 32'(bus2.pc_t), 0);
    chk("wrap.0.n", 32'(bus2.pc_n), 0);

    // Fork from SINGLE, advance twice, then n-pipe correction
    do_fork(10'h40, 10'h11);
    tick(); idle();
    chk_st("fork", 10'h40, 10'h11, 1, 0, 1);
    tick(); tick();
    chk_st("fork.adv", 10'h42, 10'h13, 1, 0, 1);
    bus.correct_en_n = 1; bus.correction_n = 10'h43;
    tick(); idle();
    chk_st("corr_n", 10'h43, 10'h43, 0, 0, 1);

    // Fork, then t-pipe correction
    do_fork(10'h100, 10'h200);
    tick(); idle();
    chk_st("fork2", 10'h100, 10'h200, 1, 0, 1);
    bus.correct_en_t = 1; bus.correction_t = 10'h20;
    tick(); idle();
    chk_st("corr_t", 10'h20, 10'h201, 0, 0, 0);

    // Nested fork parks in HOLD, applied on resolve
    do_fork(10'h60, 10'h70);
    tick();
    chk_st("nest.f1", 10'h60, 10'h70, 1, 0, 0);
    do_fork(10'h80, 10'h31);
    tick(); idle();
    chk_st("nest.hold", 10'h60, 10'h70, 1, 1, 0);
    tick();
    chk_st("nest.hold2", 10'h60, 10'h70, 1, 1, 0);
    bus.correct_en_t = 1; bus.correction_t = 10'h3FF;
    tick(); idle();
    chk_st("nest.exit", 10'h80, 10'h31, 1, 0, 0);

    // Correction and fork in the same cycle: fork wins
    bus.correct_en_n = 1; bus.correction_n = 10'h5;
    do_fork(10'h90, 10'h55);
    tick(); idle();
    chk_st("fork_wins", 10'h90, 10'h55, 1, 0, 1);

    // Stall freezes state even with events present
    bus.stall = 1; bus.correct_en_t = 1; bus.correction_t = 10'h1;
    do_fork(10'h2, 10'h3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_st("stall", 10'h90, 10'h55, 1, 0, 1);
    end
    idle();
    tick();
    chk_st("unstall", 10'h91, 10'h56, 1, 0, 1);

    // Rejoin, then correction in SINGLE is ignored
    bus.correct_en_t = 1; bus.correction_t = 10'h10;
    tick(); idle();
    chk_st("rejoin", 10'h10, 10'h57, 0, 0, 0);
    tick();
    bus.correct_en_n = 1; bus.correction_n = 10'h3;
    tick(); idle();
    chk_st("single_corr", 10'h12, 10'h59, 0, 0, 0);

    // Async reset from SINGLE with surv_t=0
    rst = 1; #1;
    chk_st("rst_async", 0, 0, 0, 0, 1);
    tick(); rst = 0;
`ifdef FORK_FETCH_PERF_EN
    force dut.u_fork_cnt.cnt_q = 16'hFFFE;
    #1 release dut.u_fork_cnt.cnt_q;
`endif

    // Three accepted forks: from SINGLE, fork-wins, and from HOLD
    do_fork(10'h100, 10'h101);
    tick(); idle();
    chk_st("pf.f1", 10'h100, 10'h101, 1, 0, 1);
    bus.correct_en_t = 1; bus.correction_t = 10'h7;
    do_fork(10'h200, 10'h201);
    tick(); idle();
    chk_st("pf.f2", 10'h200, 10'h201, 1, 0, 0);
    do_fork(10'h300, 10'h301);
    tick(); idle();
    chk_st("pf.hold", 10'h200, 10'h201, 1, 1, 0);
    tick();
    bus.correct_en_n = 1; bus.correction_n = 10'h0;
    tick(); idle();
    chk_st("pf.f3", 10'h300, 10'h301, 1, 0, 1);
`ifdef FORK_FETCH_PERF_EN
    chk("cnt.fork_sat", 32'(bus.fork_cnt), 32'hFFFF);
    chk("cnt.mis_t", 32'(bus.mispred_t_cnt), 1);
    chk("cnt.hold", 32'(bus.hold_cyc_cnt), 2);
`endif

    // Reset mid-HOLD discards the pending fork
    do_fork(10'h10, 10'h11);
    tick(); idle();
    chk_st("hold2", 10'h300, 10'h301, 1, 1, 1);
    rst = 1; #1;
    chk_st("rst_hold", 0, 0, 0, 0, 1);
`ifdef FORK_FETCH_PERF_EN
    chk("rst_hold.fork_cnt", 32'(bus.fork_cnt), 0);
    chk("rst_hold.mis_t", 32'(bus.mispred_t_cnt), 0);
    chk("rst_hold.hold", 32'(bus.hold_cyc_cnt), 0);
`endif
    tick(); rst = 0;
    tick();
    chk_st("post_rst", 1, 1, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
